// File: rtl/pp_cmd_if.sv
// Parallel-port PIO pair between the HPS and the fabric command engine.
// master = HPS side (drives the command word), slave = fabric engine.
interface pp_cmd_if;
    logic [31:0] pp_out_axi_export;
    logic [31:0] pp_in_axi_export;
    logic [7:0]  fifo_level;

    modport master (output pp_out_axi_export, input pp_in_axi_export, input fifo_level);
    modport slave  (input pp_out_axi_export, output pp_in_axi_export, output fifo_level);
endinterface

// File: rtl/pp_cmd_engine.sv
// Toggle-handshake command processor: register file plus 16-bit FIFO behind the HPS PIO pair.
// Optional macro PP_CMD_CNT_EN adds an 8-bit executed-command counter reported by STATUS.
//
// state  | meaning
// IDLE   | waiting for req toggle in pp_q to differ from req_seen
// EXEC   | decode and perform the latched command
// RDWAIT | FIFO RAM read in flight (POP only)
// RESP   | publish ack/error/result, clear busy
module pp_cmd_engine #(
    parameter int NREGS      = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic   clk_clk,
    input  logic   reset_reset,
    pp_cmd_if.slave pp
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;

    localparam logic [2:0] OP_WRITE  = 3'd1;
    localparam logic [2:0] OP_READ   = 3'd2;
    localparam logic [2:0] OP_ADD    = 3'd3;
    localparam logic [2:0] OP_PUSH   = 3'd4;
    localparam logic [2:0] OP_POP    = 3'd5;
    localparam logic [2:0] OP_STATUS = 3'd6;
    localparam logic [2:0] OP_CLEAR  = 3'd7;

    typedef enum logic [1:0] {IDLE, EXEC, RDWAIT, RESP} state_t;
    state_t state, state_nxt;

    logic [31:0]   pp_q, cmd;
    logic          req_seen;
    logic [15:0]   regs [NREGS];
    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] fifo_count;
    logic [15:0]   rd_data;
    logic          ex_err, ex_err_nxt;
    logic [15:0]   ex_res, ex_res_nxt;
    logic          resp_ack, resp_busy, resp_err;
    logic [15:0]   resp_res;
    logic [7:0]    cnt_view;

    logic          start, reg_we, push, pop, clear_all;
    logic [15:0]   reg_wdata, reg_cur, payload;
    logic [2:0]    op;
    logic [3:0]    idx;
    logic [IW-1:0] ridx;
    logic          idx_bad, fifo_full, fifo_empty;

    assign op         = cmd[30:28];
    assign idx        = cmd[27:24];
    assign payload    = cmd[15:0];
    assign ridx       = idx[IW-1:0];
    assign reg_cur    = regs[ridx];
    assign idx_bad    = ({1'b0, idx} >= 5'(NREGS));
    assign fifo_full  = (fifo_count == CW'(FIFO_DEPTH));
    assign fifo_empty = (fifo_count == '0);

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) state <= IDLE;
        else             state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        start      = 1'b0;
        ex_err_nxt = 1'b0;
        ex_res_nxt = '0;
        reg_we     = 1'b0;
        reg_wdata  = payload;
        push       = 1'b0;
        pop        = 1'b0;
        clear_all  = 1'b0;
        case (state)
            IDLE: begin
                if (pp_q[31] != req_seen) begin
                    start     = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                state_nxt = (op == OP_POP) ? RDWAIT : RESP;
                if (cmd[23:16] != '0) begin
                    ex_err_nxt = 1'b1;
                end else begin
                    case (op)
                        OP_WRITE, OP_READ, OP_ADD: begin
                            if (idx_bad) begin
                                ex_err_nxt = 1'b1;
                            end else if (op == OP_READ) begin
                                ex_res_nxt = reg_cur;
                            end else begin
                                reg_we     = 1'b1;
                                reg_wdata  = (op == OP_ADD) ? reg_cur + payload : payload;
                                ex_res_nxt = reg_wdata;
                            end
                        end
                        OP_PUSH: begin
                            if (fifo_full) ex_err_nxt = 1'b1;
                            else begin
                                push       = 1'b1;
                                ex_res_nxt = payload;
                            end
                        end
                        OP_POP: begin
                            if (fifo_empty) ex_err_nxt = 1'b1;
                            else            pop = 1'b1;
                        end
                        OP_STATUS: ex_res_nxt = {cnt_view, 6'b0, fifo_full, fifo_empty};
                        OP_CLEAR:  clear_all = 1'b1;
                        default:   ex_res_nxt = '0;
                    endcase
                end
            end
            RDWAIT:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            pp_q       <= '0;
            cmd        <= '0;
            req_seen   <= 1'b0;
            ex_err     <= 1'b0;
            ex_res     <= '0;
            resp_ack   <= 1'b0;
            resp_busy  <= 1'b0;
            resp_err   <= 1'b0;
            resp_res   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            pp_q <= pp.pp_out_axi_export;
            if (start) begin
                cmd       <= pp_q;
                req_seen  <= pp_q[31];
                resp_busy <= 1'b1;
            end
            if (state == EXEC) begin
                ex_err <= ex_err_nxt;
                ex_res <= ex_res_nxt;
            end
            // rd_data was read from the head on the EXEC edge
            if (state == RDWAIT && !ex_err) ex_res <= rd_data;
            if (state == RESP) begin
                resp_ack  <= req_seen;
                resp_busy <= 1'b0;
                resp_err  <= ex_err;
                resp_res  <= ex_res;
            end
            if (clear_all) begin
                for (int i = 0; i < NREGS; i++) regs[i] <= '0;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fifo_count <= '0;
            end else begin
                if (reg_we) regs[ridx] <= reg_wdata;
                if (push) begin
                    wr_ptr     <= wr_ptr + 1'b1;
                    fifo_count <= fifo_count + 1'b1;
                end
                if (pop) begin
                    rd_ptr     <= rd_ptr + 1'b1;
                    fifo_count <= fifo_count - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (push) mem[wr_ptr] <= payload;
        rd_data <= mem[rd_ptr];
    end

`ifdef PP_CMD_CNT_EN
    logic [7:0] cmd_cnt;
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset)         cmd_cnt <= '0;
        else if (state == EXEC)  cmd_cnt <= clear_all ? 8'h00 : cmd_cnt + 8'd1;
    end
    // STATUS counts itself
    assign cnt_view = cmd_cnt + 8'd1;
`else
    assign cnt_view = 8'h00;
`endif

    assign pp.pp_in_axi_export = {resp_ack, resp_busy, resp_err, 5'b0, 8'(fifo_count), resp_res};
    assign pp.fifo_level       = 8'(fifo_count);
endmodule

// File: tb/tb_pp_cmd_engine.sv
// Directed bench for pp_cmd_engine: vector table plus FIFO-fill, double-toggle and mid-command reset sequences.
module tb_pp_cmd_engine;
`ifdef PP_CMD_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif
    localparam logic [2:0] NOP = 3'd0, WR = 3'd1, RD = 3'd2, ADD = 3'd3,
                           PUSH = 3'd4, POP = 3'd5, STAT = 3'd6, CLR = 3'd7;

    logic clk_clk, reset_reset;
    pp_cmd_if pp ();

    pp_cmd_engine #(.NREGS(8), .FIFO_DEPTH(16)) dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset), .pp(pp.slave)
    );

    initial begin
        clk_clk = 1'b0;
        forever #5 clk_clk = ~clk_clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int   n_checks = 0;
    int   n_errors = 0;
    logic tog      = 1'b0;
    logic [7:0] ncmd = 8'h00;

    typedef struct {
        logic [2:0]  op;
        logic [3:0]  idx;
        logic [7:0]  rsvd;
        logic [15:0] pl;
        bit          err;
        logic [15:0] res;
        logic [7:0]  cnt;
        int          lat;
        bit          stat;
    } vec_t;
    vec_t vt [21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issues one command with a fresh toggle and checks the response when ack flips.
    task automatic send(input logic [2:0] op, input logic [3:0] idx, input logic [7:0] rsvd,
                        input logic [15:0] pl, input bit exp_err, input logic [15:0] exp_res,
                        input logic [7:0] exp_cnt, input int exp_lat, input bit stat);
        int lat;
        logic [15:0] r;
        lat = 0;
        tog = ~tog;
        pp.pp_out_axi_export = {tog, op, idx, rsvd, pl};
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk_clk); #1;
            if (pp.pp_in_axi_export[31] == tog) begin
                lat = k;
                break;
            end
        end
        ncmd = ncmd + 8'd1;
        if (op == CLR && !exp_err) ncmd = 8'h00;
        r = exp_res;
        if (stat) r = r | {(CNT_EN ? ncmd : 8'h00), 8'h00};
        chk("latency", lat, exp_lat);
        chk("busy", pp.pp_in_axi_export[30], 0);
        chk("error", pp.pp_in_axi_export[29], exp_err);
        chk("result", pp.pp_in_axi_export[15:0], r);
        chk("count", pp.pp_in_axi_export[23:16], exp_cnt);
        chk("fifo_level", pp.fifo_level, exp_cnt);
    endtask

    initial begin
        //         op    idx   rsvd   payload   err   result    cnt  lat stat
        vt[0]  = '{WR,   4'd3, 8'h00, 16'h1234, 1'b0, 16'h1234, 8'd0, 4, 1'b0};
        vt[1]  = '{RD,   4'd3, 8'h00, 16'h0000, 1'b0, 16'h1234, 8'd0, 4, 1'b0};
        vt[2]  = '{WR,   4'd0, 8'h00, 16'hFFF0, 1'b0, 16'hFFF0, 8'd0, 4, 1'b0};
        vt[3]  = '{ADD,  4'd0, 8'h00, 16'h0020, 1'b0, 16'h0010, 8'd0, 4, 1'b0};
        vt[4]  = '{RD,   4'd0, 8'h00, 16'h0000, 1'b0, 16'h0010, 8'd0, 4, 1'b0};
        vt[5]  = '{PUSH, 4'd0, 8'h00, 16'h00A1, 1'b0, 16'h00A1, 8'd1, 4, 1'b0};
        vt[6]  = '{PUSH, 4'd0, 8'h00, 16'h00A2, 1'b0, 16'h00A2, 8'd2, 4, 1'b0};
        vt[7]  = '{PUSH, 4'd0, 8'h00, 16'h00A3, 1'b0, 16'h00A3, 8'd3, 4, 1'b0};
        vt[8]  = '{POP,  4'd0, 8'h00, 16'h0000, 1'b0, 16'h00A1, 8'd2, 5, 1'b0};
        vt[9]  = '{POP,  4'd0, 8'h00, 16'h0000, 1'b0, 16'h00A2, 8'd1, 5, 1'b0};
        vt[10] = '{POP,  4'd0, 8'h00, 16'h0000, 1'b0, 16'h00A3, 8'd0, 5, 1'b0};
        vt[11] = '{POP,  4'd0, 8'h00, 16'h0000, 1'b1, 16'h0000, 8'd0, 5, 1'b0};
        vt[12] = '{RD,   4'd9, 8'h00, 16'h0000, 1'b1, 16'h0000, 8'd0, 4, 1'b0};
        vt[13] = '{WR,   4'd2, 8'h01, 16'h0005, 1'b1, 16'h0000, 8'd0, 4, 1'b0};
        vt[14] = '{RD,   4'd2, 8'h00, 16'h0000, 1'b0, 16'h0000, 8'd0, 4, 1'b0};
        vt[15] = '{NOP,  4'd0, 8'h00, 16'h0055, 1'b0, 16'h0000, 8'd0, 4, 1'b0};
        vt[16] = '{STAT, 4'd0, 8'h00, 16'h0000, 1'b0, 16'h0001, 8'd0, 4, 1'b1};
        vt[17] = '{ADD,  4'd7, 8'h00, 16'h0003, 1'b0, 16'h0003, 8'd0, 4, 1'b0};
        vt[18] = '{CLR,  4'd0, 8'h00, 16'h0000, 1'b0, 16'h0000, 8'd0, 4, 1'b0};
        vt[19] = '{RD,   4'd7, 8'h00, 16'h0000, 1'b0, 16'h0000, 8'd0, 4, 1'b0};
        vt[20] = '{RD,   4'd3, 8'h00, 16'h0000, 1'b0, 16'h0000, 8'd0, 4, 1'b0};

        reset_reset = 1'b1;
        pp.pp_out_axi_export = '0;
        repeat (3) @(posedge clk_clk);
        #1;
        chk("reset pp_in", pp.pp_in_axi_export, 32'h0);
        @(negedge clk_clk) reset_reset = 1'b0;
        @(posedge clk_clk); #1;
        chk("post-reset pp_in", pp.pp_in_axi_export, 32'h0);
        chk("post-reset level", pp.fifo_level, 0);

        for (int i = 0; i < 21; i++)
            send(vt[i].op, vt[i].idx, vt[i].rsvd, vt[i].pl, vt[i].err,
                 vt[i].res, vt[i].cnt, vt[i].lat, vt[i].stat);

        // Fill past capacity; the overflowing push must error and leave count at depth
        for (int i = 0; i < 17; i++)
            send(PUSH, 4'd0, 8'h00, 16'h0100 + 16'(i), (i == 16),
                 (i == 16) ? 16'h0000 : 16'h0100 + 16'(i),
                 (i == 16) ? 8'd16 : 8'(i + 1), 4, 1'b0);
        send(STAT, 4'd0, 8'h00, 16'h0000, 1'b0, 16'h0002, 8'd16, 4, 1'b1);
        send(POP,  4'd0, 8'h00, 16'h0000, 1'b0, 16'h0100, 8'd15, 5, 1'b0);
        send(CLR,  4'd0, 8'h00, 16'h0000, 1'b0, 16'h0000, 8'd0, 4, 1'b0);

        // Double toggle while busy must not start a second command
        tog = ~tog;
        pp.pp_out_axi_export = {tog, RD, 4'd3, 8'h00, 16'h0000};
        @(posedge clk_clk); #1;
        @(posedge clk_clk); #1;
        chk("busy during exec", pp.pp_in_axi_export[30], 1);
        pp.pp_out_axi_export[31] = ~tog;
        @(posedge clk_clk); #1;
        pp.pp_out_axi_export[31] = tog;
        ncmd = ncmd + 8'd1;
        repeat (12) @(posedge clk_clk);
        #1;
        chk("double toggle dropped", pp.pp_in_axi_export, {tog, 31'h0});

        // Reset during EXEC abandons the write
        tog = ~tog;
        pp.pp_out_axi_export = {tog, WR, 4'd1, 8'h00, 16'hBEEF};
        @(posedge clk_clk); #1;
        @(posedge clk_clk); #1;
        reset_reset = 1'b1;
        pp.pp_out_axi_export = '0;
        tog  = 1'b0;
        ncmd = 8'h00;
        #1;
        chk("async reset pp_in", pp.pp_in_axi_export, 32'h0);
        @(negedge clk_clk) reset_reset = 1'b0;
        @(posedge clk_clk); #1;

        send(RD,   4'd1, 8'h00, 16'h0000, 1'b0, 16'h0000, 8'd0, 4, 1'b0);
        send(WR,   4'd2, 8'h00, 16'h0007, 1'b0, 16'h0007, 8'd0, 4, 1'b0);
        send(NOP,  4'd0, 8'h00, 16'h0000, 1'b0, 16'h0000, 8'd0, 4, 1'b0);
        send(PUSH, 4'd0, 8'h00, 16'h0009, 1'b0, 16'h0009, 8'd1, 4, 1'b0);
        send(POP,  4'd0, 8'h00, 16'h0000, 1'b0, 16'h0009, 8'd0, 5, 1'b0);
        send(STAT, 4'd0, 8'h00, 16'h0000, 1'b0, 16'h0001, 8'd0, 4, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/pp_cmd_engine.md
Name: pp_cmd_engine

Overview:
- Fabric-side command processor on the HPS parallel-port PIO pair.
- Consumes the 32-bit word the HPS drives out of the system (pp_out_axi_export) and produces the 32-bit status/result word the HPS reads back (pp_in_axi_export).
- Commands are framed by a toggle handshake. The block executes them against a small register file and a 16-bit FIFO.
- Runs on the system clock; same domain as the PIO.

Parameters:
- NREGS, 8, number of 16-bit registers; 1..16.
- FIFO_DEPTH, 16, FIFO entries; power of 2, 2..128.

Ports:
- clk_clk  in  1  system clock.
- reset_reset  in  1  asynchronous reset, active-high.
- pp_out_axi_export  in  32  command word from HPS: [31] req toggle, [30:28] opcode, [27:24] reg index, [23:16] reserved, [15:0] payload.
- pp_in_axi_export  out  32  response word to HPS: [31] ack toggle, [30] busy, [29] error, [28:24] 0, [23:16] FIFO count, [15:0] result.
- fifo_level  out  8  current FIFO occupancy, for fabric debug/LEDs.

Behaviour:
- Clock and reset
  - Single clock, clk_clk.
  - reset_reset is asynchronous and active-high.
  - Reset values: pp_in_axi_export = 0, fifo_level = 0, all registers 0, FIFO empty, req_seen = 0, state IDLE.
  - The HPS PIO shares this reset, so bit31 is 0 after reset.
- Input staging: pp_out_axi_export is registered every cycle into pp_q.
- FSM: IDLE -> EXEC -> [RDWAIT] -> RESP -> IDLE.
  - IDLE: if pp_q[31] != req_seen, latch pp_q into cmd, set req_seen = pp_q[31], busy = 1, go to EXEC.
  - EXEC: perform the opcode. POP goes to RDWAIT, because FIFO RAM read is registered. All other opcodes go to RESP.
  - RDWAIT: capture FIFO read data, then go to RESP.
  - RESP: register the response, with ack = req_seen, busy = 0, and error/result from EXEC. Go to IDLE.
- Latency: pp_in ack flips exactly 4 clk edges after pp_out[31] changes (5 for POP).
- Opcodes:
  - 0 NOP: result = 0.
  - 1 WRITE: reg[idx] = payload; result = payload.
  - 2 READ: result = reg[idx].
  - 3 ADD: reg[idx] = reg[idx] + payload mod 2^16, carry discarded; result = new value.
  - 4 PUSH: write payload to FIFO; result = payload.
  - 5 POP: result = FIFO head, which is removed.
  - 6 STATUS: result = {cmd_cnt[7:0], 6'b0, full, empty}.
  - 7 CLEAR: all regs = 0, FIFO flushed; result = 0.
- Errors (error = 1, no state change, result = 0):
  - idx >= NREGS on WRITE/READ/ADD.
  - PUSH when full.
  - POP when empty.
  - reserved bits [23:16] nonzero on any opcode.
- Error scope: the error bit applies to the current response only and clears on the next response.
- FIFO:
  - Wrap-around pointers with a separate count; count == FIFO_DEPTH means full.
  - fifo_level and pp_in[23:16] update on the cycle after the push or pop.
- Protocol boundaries:
  - Toggle changes during EXEC/RDWAIT/RESP are not sampled until IDLE.
  - A double toggle before ack is indistinguishable from no toggle and is dropped. The HPS driver must wait for the ack to match before issuing the next command.
- Reset mid-command: the command is abandoned, ack returns to 0, and no partial register/FIFO update is retained beyond what has already been written.

Optional Feature:
- PP_CMD_CNT_EN defined:
  - 8-bit cmd_cnt increments once per executed command, including errored ones, wrapping 255 -> 0.
  - CLEAR resets it to 0 after counting itself.
  - STATUS reports it in result[15:8].
- PP_CMD_CNT_EN undefined: no counter logic; result[15:8] of STATUS reads 0.

Test Plan:
- Reset, then WRITE idx 3 payload 0x1234 with toggle 0->1 -> ack = 1 after 4 cycles, error 0, result 0x1234; READ idx 3 with toggle 1->0 -> result 0x1234.
- ADD idx 0: WRITE 0xFFF0, then ADD 0x0020 -> result 0x0010, no error (wrap).
- PUSH 0xA1, 0xA2, 0xA3 -> count 3; POP -> 0x00A1 in 5 cycles, count 2; POP twice more -> 0xA2, 0xA3; POP again -> error 1, result 0, count 0.
- PUSH FIFO_DEPTH+1 words -> last response error 1, count 16; STATUS -> result[1:0] = 2'b10.
- READ idx 9 with NREGS = 8 -> error 1; toggle bit flipped twice during busy -> no second command executes.
- With PP_CMD_CNT_EN: 5 commands, then STATUS -> result[15:8] = 6; assert reset_reset mid-EXEC -> pp_in = 0 asynchronously, next command executes normally.
